// File: rtl/conv_layer_sched.sv
// conv_layer_sched
// Layer-level scheduler placed in front of the CONV instruction generator.
// The host pushes packed layer descriptors into a small FIFO. Illegal geometry
// is screened out at push time. Legal layers are issued one at a time to the
// generator, and the next layer is only issued after the current one reports
// conv_complete.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   desc_valid/ready/data  host descriptor push (ready = FIFO not full)
//   sched_en        level; 0 holds the queue (an asserted cmd_valid is kept)
//   abort           pulse; flushes queued descriptors, the in-flight layer runs on
//   cmd_data/valid/ready   registered descriptor handshake towards the generator
//   conv_complete   1-cycle done pulse from the generator
//   busy, q_level   progress status
//   layers_done     completed-layer counter (wraps)
//   err_reject      sticky flag: an illegal descriptor was dropped
//   irq             sticky flag: the last queued layer has completed
//   irq_clr         pulse; clears irq and err_reject
//
// Descriptor packing, MSB->LSB:
//   feature_baseaddr, kernel_baseaddr, wb_baseaddr, feature_width,
//   feature_height, feature_chin, feature_chout, kernel_sizeh, kernel_sizew,
//   stride, has_bias, has_relu
module conv_layer_sched #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int DESC_W = 3*ADDR_W + 7*DATA_W + 2,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DESC_W-1:0] desc_data,
    input  logic              sched_en,
    input  logic              abort,
    output logic [DESC_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              conv_complete,
    output logic              busy,
    output logic [LVL_W-1:0]  q_level,
    output logic [15:0]       layers_done,
    output logic              err_reject,
    output logic              irq,
    input  logic              irq_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // A descriptor is legal when the kernel window is non-empty, fits inside the
    // feature map, and the stride is non-zero.
    function automatic logic desc_legal(input logic [DESC_W-1:0] d);
        logic [DATA_W-1:0] f_w;
        logic [DATA_W-1:0] f_h;
        logic [DATA_W-1:0] k_h;
        logic [DATA_W-1:0] k_w;
        logic [DATA_W-1:0] strd;
        f_w  = d[2 + 6*DATA_W +: DATA_W];
        f_h  = d[2 + 5*DATA_W +: DATA_W];
        k_h  = d[2 + 2*DATA_W +: DATA_W];
        k_w  = d[2 + 1*DATA_W +: DATA_W];
        strd = d[2 +: DATA_W];
        return (strd != {DATA_W{1'b0}}) && (k_w != {DATA_W{1'b0}}) &&
               (k_h != {DATA_W{1'b0}}) && (k_w <= f_w) && (k_h <= f_h);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DESC_W-1:0] fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [DESC_W-1:0] cmd_data_r;
    logic              cmd_valid_r;
    logic [15:0]       layers_done_r;
    logic              err_reject_r;
    logic              irq_r;

    logic empty_s;
    logic full_s;
    logic push_s;
    logic legal_s;
    logic wr_s;
    logic pop_s;
    logic complete_s;

    assign empty_s    = (level_r == {LVL_W{1'b0}});
    assign full_s     = (level_r == LVL_FULL);
    assign push_s     = desc_valid && !full_s;
    assign legal_s    = desc_legal(desc_data);
    // A push coinciding with abort is dropped together with the flushed queue.
    assign wr_s       = push_s && legal_s && !abort;
    assign complete_s = (state_r == ST_WAIT) && conv_complete;

    assign desc_ready  = !full_s;
    assign busy        = (state_r != ST_IDLE) || !empty_s;
    assign q_level     = level_r;
    assign cmd_data    = cmd_data_r;
    assign cmd_valid   = cmd_valid_r;
    assign layers_done = layers_done_r;
    assign err_reject  = err_reject_r;
    assign irq         = irq_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and pop decision; the FIFO head seen here is registered, so
    // a descriptor pushed this cycle cannot be popped before the next one.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sched_en && !empty_s) begin
                    state_nxt_s = ST_ISSUE;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // cmd_valid is high for the whole ISSUE state, so cmd_ready alone
                // completes the handshake; sched_en has no effect here.
                if (cmd_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (conv_complete) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Descriptor FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {DESC_W{1'b0}};
            end
        end else if (wr_s) begin
            fifo_mem_r[wr_ptr_r] <= desc_data;
        end
    end

    // FIFO pointers and occupancy; abort flushes everything still queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (abort) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Command register towards the generator; held stable until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_data_r  <= {DESC_W{1'b0}};
            cmd_valid_r <= 1'b0;
        end else if (pop_s) begin
            cmd_data_r  <= fifo_mem_r[rd_ptr_r];
            cmd_valid_r <= 1'b1;
        end else if (cmd_valid_r && cmd_ready) begin
            cmd_valid_r <= 1'b0;
        end
    end

    // Completion counter and sticky status flags; irq_clr wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layers_done_r <= 16'd0;
            irq_r         <= 1'b0;
            err_reject_r  <= 1'b0;
        end else begin
            if (complete_s) begin
                layers_done_r <= layers_done_r + 16'd1;
            end
            if (irq_clr) begin
                irq_r <= 1'b0;
            end else if (complete_s && empty_s) begin
                irq_r <= 1'b1;
            end
            if (irq_clr) begin
                err_reject_r <= 1'b0;
            end else if (push_s && !legal_s) begin
                err_reject_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: directed scenarios plus a randomized
// phase, all compared every cycle against a queue-based reference model.
module tb_conv_layer_sched;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DESCW = 3*AW + 7*DW + 2;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             desc_valid;
    logic             desc_ready;
    logic [DESCW-1:0] desc_data;
    logic             sched_en;
    logic             abort;
    logic [DESCW-1:0] cmd_data;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             conv_complete;
    logic             busy;
    logic [LVLW-1:0]  q_level;
    logic [15:0]      layers_done;
    logic             err_reject;
    logic             irq;
    logic             irq_clr;

    conv_layer_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .sched_en(sched_en), .abort(abort),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .conv_complete(conv_complete), .busy(busy), .q_level(q_level),
        .layers_done(layers_done), .err_reject(err_reject), .irq(irq),
        .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of legal descriptors plus the layer in the generator.
    logic [DESCW-1:0] mq[$];
    bit               m_pending;   // descriptor presented, not yet accepted
    bit               m_inflight;  // accepted, waiting for completion
    logic [DESCW-1:0] m_cmd;
    logic [15:0]      m_done;
    bit               m_irq;
    bit               m_err;
    bit               cur_legal;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pending  = 1'b0;
        m_inflight = 1'b0;
        m_cmd      = '0;
        m_done     = 16'd0;
        m_irq      = 1'b0;
        m_err      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit acc, do_pop, hs, fin, was_empty;
        acc       = desc_valid && (mq.size() < DEPTH);
        do_pop    = !m_pending && !m_inflight && sched_en && (mq.size() > 0);
        hs        = m_pending && cmd_ready;
        fin       = m_inflight && conv_complete;
        was_empty = (mq.size() == 0);
        if (hs) begin
            m_pending  = 1'b0;
            m_inflight = 1'b1;
        end
        if (fin) begin
            m_inflight = 1'b0;
            m_done     = m_done + 16'd1;
        end
        if (irq_clr) m_irq = 1'b0;
        else if (fin && was_empty) m_irq = 1'b1;
        if (irq_clr) m_err = 1'b0;
        else if (acc && !cur_legal) m_err = 1'b1;
        if (do_pop) begin
            m_cmd     = mq.pop_front();
            m_pending = 1'b1;
        end
        if (abort) mq.delete();
        else if (acc && cur_legal) mq.push_back(desc_data);
    endtask

    task automatic compare_all();
        check("cmd_valid",   {511'd0, cmd_valid}, {511'd0, m_pending});
        check("cmd_data",    cmd_data, m_cmd);
        check("desc_ready",  {511'd0, desc_ready}, {511'd0, (mq.size() < DEPTH)});
        check("q_level",     q_level, mq.size());
        check("layers_done", layers_done, m_done);
        check("irq",         {511'd0, irq}, {511'd0, m_irq});
        check("err_reject",  {511'd0, err_reject}, {511'd0, m_err});
        check("busy",        {511'd0, busy},
              {511'd0, (m_pending || m_inflight || mq.size() != 0)});
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_desc(input int fw, input int fh, input int kh, input int kw, input int st);
        desc_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'(fw), 32'(fh),
                     32'($urandom_range(1, 64)), 32'($urandom_range(1, 64)),
                     32'(kh), 32'(kw), 32'(st), 1'($urandom), 1'($urandom)};
        cur_legal = (st != 0) && (kw != 0) && (kh != 0) && (kw <= fw) && (kh <= fh);
    endtask

    task automatic push_one(input int fw, input int fh, input int kh, input int kw, input int st);
        set_desc(fw, fh, kh, kw, st);
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!cmd_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", {511'd0, cmd_valid}, 512'd1);
    endtask

    task automatic pulse_complete();
        conv_complete = 1'b1;
        tick();
        conv_complete = 1'b0;
    endtask

    logic [DESCW-1:0] exp_q [4];
    logic [DESCW-1:0] held;
    logic [15:0]      base;

    initial begin
        rst_n = 1'b0; desc_valid = 1'b0; desc_data = '0; sched_en = 1'b0;
        abort = 1'b0; cmd_ready = 1'b0; conv_complete = 1'b0; irq_clr = 1'b0;
        cur_legal = 1'b0;
        model_reset();
        #22;
        check("rst_cmd_valid", {511'd0, cmd_valid}, 512'd0);
        check("rst_desc_ready", {511'd0, desc_ready}, 512'd1);
        check("rst_q_level", q_level, 512'd0);
        check("rst_busy", {511'd0, busy}, 512'd0);
        rst_n = 1'b1;

        // 1: single legal descriptor, minimum latency
        sched_en = 1'b1; cmd_ready = 1'b1;
        push_one(8, 8, 3, 3, 1);
        check("t1_valid_t1", {511'd0, cmd_valid}, 512'd0);
        tick();
        check("t1_valid_t2", {511'd0, cmd_valid}, 512'd1);
        tick();
        check("t1_valid_drop", {511'd0, cmd_valid}, 512'd0);
        pulse_complete();
        check("t1_layers", layers_done, 512'd1);
        check("t1_irq", {511'd0, irq}, 512'd1);
        check("t1_busy", {511'd0, busy}, 512'd0);

        // 2: fill the queue while held, then drain in order
        sched_en = 1'b0;
        base = layers_done;
        for (int i = 0; i < 4; i++) begin
            push_one(16, 16, 3, 3, 1);
            exp_q[i] = desc_data;
        end
        check("t2_level_full", q_level, 512'd4);
        check("t2_ready_full", {511'd0, desc_ready}, 512'd0);
        set_desc(16, 16, 1, 1, 1);
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
        check("t2_refused", q_level, 512'd4);
        sched_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(5);
            check("t2_order", cmd_data, exp_q[i]);
            tick();
            tick();
            tick();
            check("t2_no_early", {511'd0, cmd_valid}, 512'd0);
            pulse_complete();
        end
        check("t2_layers", layers_done, 512'(base + 16'd4));

        // 3: illegal descriptors are dropped and flagged
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        push_one(8, 8, 3, 3, 0);
        push_one(8, 8, 3, 9, 1);
        tick();
        check("t3_err", {511'd0, err_reject}, 512'd1);
        check("t3_level", q_level, 512'd0);
        check("t3_no_issue", {511'd0, cmd_valid}, 512'd0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("t3_err_clr", {511'd0, err_reject}, 512'd0);

        // 4: generator stalls while sched_en drops
        cmd_ready = 1'b0;
        push_one(12, 10, 2, 5, 2);
        wait_valid(5);
        held = cmd_data;
        sched_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", {511'd0, cmd_valid}, 512'd1);
            check("t4_hold_data", cmd_data, held);
        end
        cmd_ready = 1'b1;
        tick();
        check("t4_accepted", {511'd0, cmd_valid}, 512'd0);
        pulse_complete();

        // 5: abort while a layer is in flight
        push_one(8, 8, 3, 3, 1);
        push_one(8, 8, 3, 3, 1);
        push_one(8, 8, 3, 3, 1);
        sched_en = 1'b1;
        wait_valid(5);
        tick();
        base = layers_done;
        abort = 1'b1; tick(); abort = 1'b0;
        check("t5_flushed", q_level, 512'd0);
        tick();
        pulse_complete();
        check("t5_layers", layers_done, 512'(base + 16'd1));
        for (int i = 0; i < 4; i++) tick();
        check("t5_nothing", {511'd0, cmd_valid}, 512'd0);
        check("t5_idle", {511'd0, busy}, 512'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int fw, fh;
            fw = $urandom_range(1, 16);
            fh = $urandom_range(1, 16);
            set_desc(fw, fh,
                     ($urandom % 4 == 0) ? $urandom_range(0, 20) : $urandom_range(1, fh),
                     ($urandom % 4 == 0) ? $urandom_range(0, 20) : $urandom_range(1, fw),
                     ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3));
            desc_valid    = ($urandom % 3 == 0);
            sched_en      = ($urandom % 8 != 0);
            cmd_ready     = ($urandom % 2 == 0);
            conv_complete = ($urandom % 6 == 0);
            abort         = ($urandom % 80 == 0);
            irq_clr       = ($urandom % 40 == 0);
            tick();
        end
        desc_valid = 1'b0; abort = 1'b0; irq_clr = 1'b0; conv_complete = 1'b0;
        sched_en = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 6 && busy; i++) begin
            pulse_complete();
            for (int j = 0; j < 3; j++) tick();
        end

        // 6: asynchronous reset during WAIT
        sched_en = 1'b1; cmd_ready = 1'b1;
        push_one(8, 8, 3, 3, 1);
        push_one(8, 8, 3, 3, 1);
        wait_valid(5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_cmd_valid", {511'd0, cmd_valid}, 512'd0);
        check("t6_cmd_data", cmd_data, 512'd0);
        check("t6_busy", {511'd0, busy}, 512'd0);
        check("t6_q_level", q_level, 512'd0);
        check("t6_layers", layers_done, 512'd0);
        check("t6_irq", {511'd0, irq}, 512'd0);
        check("t6_ready", {511'd0, desc_ready}, 512'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
